// File: rtl/opl_exp_sched.sv
// Shared exp-LUT scheduler: round-robin arbitration of log-domain operator
// requests into one registered LUT, producing id-tagged signed linear samples.
package opl_exp_sched_pkg;
  localparam int unsigned REQ_W     = 13;
  localparam int unsigned ATT_W     = 12;
  localparam int unsigned LUT_IN_W  = 8;
  localparam int unsigned LUT_OUT_W = 10;
  localparam int unsigned SH_W      = 4;
  localparam int unsigned MAG_W     = 12;
  localparam int unsigned RES_W     = 13;

  typedef struct packed {
    logic             sign;
    logic [ATT_W-1:0] att;
  } opl_req_t;
endpackage

module opl_exp_sched
  import opl_exp_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*REQ_W-1:0] req_data,
  output logic [LUT_IN_W-1:0]      lut_in,
  input  logic [LUT_OUT_W-1:0]     lut_out,
  output logic                     res_valid,
  output logic [ID_W-1:0]          res_id,
  output logic [RES_W-1:0]         res_data,
  output logic                     busy
);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            sign;
    logic [SH_W-1:0] sh;
  } stage_t;

  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [LUT_IN_W-1:0] lut_in_q, lut_in_d;
  stage_t              s1_q, s1_d;
  stage_t              s2_q, s2_d;
  logic                res_valid_q, res_valid_d;
  logic [ID_W-1:0]     res_id_q, res_id_d;
  logic [RES_W-1:0]    res_data_q, res_data_d;

  logic                grant_vld;
  logic [ID_W-1:0]     grant_idx;
  logic                hi_hit, lo_hit;
  logic [ID_W-1:0]     hi_idx, lo_idx;
  logic                accept;
  opl_req_t            sel_req;
  logic [MAG_W-1:0]    mag;

  // Round-robin: lowest valid index above ptr wins, else lowest valid at or below ptr.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (ID_W'(i) > ptr_q) begin
          if (!hi_hit) begin
            hi_hit = 1'b1;
            hi_idx = ID_W'(i);
          end
        end else if (!lo_hit) begin
          lo_hit = 1'b1;
          lo_idx = ID_W'(i);
        end
      end
    end
    grant_vld = hi_hit | lo_hit;
    grant_idx = hi_hit ? hi_idx : lo_idx;
  end

  assign accept = grant_vld & rst_n;

  // Grant decode and request payload mux.
  always_comb begin
    req_ready = '0;
    sel_req   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        req_ready[i] = accept;
        sel_req      = opl_req_t'(req_data[REQ_W*i +: REQ_W]);
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    lut_in_d    = lut_in_q;
    s1_d        = s1_q;
    s1_d.vld    = 1'b0;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;

    if (accept) begin
      ptr_d     = grant_idx;
      lut_in_d  = ~sel_req.att[LUT_IN_W-1:0];
      s1_d.vld  = 1'b1;
      s1_d.id   = grant_idx;
      s1_d.sign = sel_req.sign;
      s1_d.sh   = sel_req.att[ATT_W-1 -: SH_W];
    end

    // The LUT registers lut_in alongside this stage, so s2 lines up with lut_out.
    s2_d = s1_q;

    // Implicit leading one, scaled by 2, then attenuated by the octave shift.
    mag         = MAG_W'({1'b1, lut_out, 1'b0}) >> s2_q.sh;
    res_valid_d = s2_q.vld;
    if (s2_q.vld) begin
      res_id_d   = s2_q.id;
      res_data_d = s2_q.sign ? ~{1'b0, mag} : {1'b0, mag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= ID_W'(NUM_REQ - 1);
      lut_in_q    <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      lut_in_q    <= lut_in_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
    end
  end

  assign lut_in    = lut_in_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign busy      = s1_q.vld | s2_q.vld | res_valid_q;

endmodule
